reflet_float_minmax: RTL
========================

REFLET_FLOAT_MINMAX -- requirements
Module: reflet_float_minmax

Interface
REQ-001 SHALL have parameter float_size, default 32, the float word width in bits.
REQ-002 SHALL have parameter count_size, default 16, the element-counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a new batch, honoured only in IDLE.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is presented.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_data.
REQ-008 SHALL have port in_data, input, float_size bits: the stream element.
REQ-009 SHALL have port in_last, input, 1 bit: marks the final element of the batch.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is held.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port min_out, output, float_size bits: the smallest element of the batch.
REQ-013 SHALL have port max_out, output, float_size bits: the largest element of the batch.
REQ-014 SHALL have port count_out, output, count_size bits: the number of accepted elements.

Function
REQ-015 SHALL implement states IDLE, ACCUM and DONE: IDLE->ACCUM on start, ACCUM->DONE on the accepted in_last beat, DONE->IDLE on out_valid&&out_ready.
REQ-016 SHALL accept a beat when in_valid&&in_ready; in_ready=1 only in ACCUM.
REQ-017 SHALL load the first accepted beat of a batch into both min and max unconditionally.
REQ-018 SHALL, for later beats, replace min when in_data<min and replace max when max<in_data, using the strict_less result of reflet_float_comp (enable=1).
REQ-019 SHALL keep the stored value on ties (equal); the earliest occurrence wins.
REQ-020 SHALL register results; min_out, max_out and count_out reflect a beat one cycle after its acceptance.
REQ-021 SHALL assert out_valid only in DONE, the cycle after the in_last beat is accepted, and hold outputs stable until out_ready.
REQ-022 SHALL saturate count at 2^count_size-1; further beats still update min and max.
REQ-023 SHALL ignore start outside IDLE, and ignore in_valid outside ACCUM.
REQ-024 SHALL, in a single cycle with start and out_ready both high in DONE, go to IDLE only; start is not latched.
REQ-025 SHALL clear min, max and count on IDLE->ACCUM.

Reset
REQ-026 SHALL on reset low, asynchronously: state=IDLE; min_out, max_out and count_out =0; out_valid=0; in_ready=0.
REQ-027 SHALL abandon a batch in progress at reset without asserting out_valid after release.

Configuration
REQ-028 SHALL, with REFLET_FLOAT_MINMAX_INDEX_EN defined, add outputs min_idx and max_idx (count_size bits each): the zero-based beat index of the retained min and max, reset to 0 and stalling at saturation.
REQ-029 SHALL, without the macro, omit those ports and all their logic.

Structure
REQ-030 SHALL put the state enum constants (IDLE=0, ACCUM=1, DONE=2) in the shared reflet_float definitions header, alongside the width defaults.
REQ-031 SHALL instantiate reflet_float_comp twice as sub-modules: in_data vs min, and max vs in_data.

Verification
REQ-032 SHALL verify: start; beats 3F800000, 40000000, BF000000(last) -> out_valid, min_out=BF000000, max_out=40000000, count_out=3.
REQ-033 SHALL verify: a single beat 41200000 with last -> min_out=max_out=41200000, count_out=1.
REQ-034 SHALL verify: out_ready held low for 5 cycles -> outputs stable and in_ready=0; then out_ready=1 -> IDLE the next cycle.
REQ-035 SHALL verify: reset pulsed low after 2 beats -> all outputs 0 immediately, and no out_valid after release.
REQ-036 SHALL verify: count_size=2 with 5 beats -> count_out=3, and min and max correct.
REQ-037 SHALL verify, with INDEX_EN: beats 40000000, 3F800000, 3F800000(last) -> min_idx=1, max_idx=0.

Source files
------------

// File: rtl/reflet_float_pkg.sv
// Shared reflet_float definitions: width defaults, min/max batch FSM states
// and a helper giving the exponent width of a float format.
package reflet_float_pkg;

    localparam int FLOAT_SIZE_DEF = 32;
    localparam int COUNT_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } minmax_state_e;

    // Exponent field width for half, single and double; single otherwise.
    function automatic int exp_bits(input int fsize);
        case (fsize)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

endpackage

// File: rtl/reflet_float_comp.sv
// IEEE-754 strict less-than: a < b. +0 and -0 compare equal, any NaN
// operand yields 0, and enable=0 forces 0.
module reflet_float_comp
    import reflet_float_pkg::*;
#(
    parameter int float_size = FLOAT_SIZE_DEF
) (
    input  logic                  enable,
    input  logic [float_size-1:0] a,
    input  logic [float_size-1:0] b,
    output logic                  strict_less
);

    localparam int EXP_W = exp_bits(float_size);
    localparam int MAN_W = float_size - 1 - EXP_W;

    logic [float_size-2:0] a_mag, b_mag;
    logic                  a_nan, b_nan, both_zero;

    always_comb begin
        a_mag       = a[float_size-2:0];
        b_mag       = b[float_size-2:0];
        a_nan       = (&a[float_size-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        b_nan       = (&b[float_size-2 -: EXP_W]) && (|b[MAN_W-1:0]);
        both_zero   = ~|a_mag && ~|b_mag;
        strict_less = 1'b0;
        if (enable && !a_nan && !b_nan && !both_zero) begin
            // Sign-magnitude: negative magnitudes order in reverse.
            case ({a[float_size-1], b[float_size-1]})
                2'b10:   strict_less = 1'b1;
                2'b01:   strict_less = 1'b0;
                2'b00:   strict_less = a_mag < b_mag;
                default: strict_less = a_mag > b_mag;
            endcase
        end
    end

endmodule

// File: rtl/reflet_float_minmax.sv
// Streaming min/max/count over a batch of floats, IDLE -> ACCUM -> DONE.
// Define REFLET_FLOAT_MINMAX_INDEX_EN to add min_idx/max_idx outputs.
module reflet_float_minmax
    import reflet_float_pkg::*;
#(
    parameter int float_size = FLOAT_SIZE_DEF,
    parameter int count_size = COUNT_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [float_size-1:0] min_out,
    output logic [float_size-1:0] max_out,
    output logic [count_size-1:0] count_out
`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
    ,
    output logic [count_size-1:0] min_idx,
    output logic [count_size-1:0] max_idx
`endif
);

    minmax_state_e         state_q, state_d;
    logic [float_size-1:0] min_q, min_d, max_q, max_d;
    logic [count_size-1:0] cnt_q, cnt_d;
    logic                  lt_min, gt_max, accept;

    reflet_float_comp #(.float_size(float_size)) u_cmp_min (
        .enable(1'b1), .a(in_data), .b(min_q), .strict_less(lt_min)
    );
    reflet_float_comp #(.float_size(float_size)) u_cmp_max (
        .enable(1'b1), .a(max_q), .b(in_data), .strict_less(gt_max)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign min_out   = min_q;
    assign max_out   = max_q;
    assign count_out = cnt_q;

    // Count only returns to zero on a new batch, so zero marks the first beat.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                min_d   = '0;
                max_d   = '0;
                cnt_d   = '0;
            end
            ACCUM: if (accept) begin
                if (cnt_q == '0 || lt_min) min_d = in_data;
                if (cnt_q == '0 || gt_max) max_d = in_data;
                if (cnt_q != '1)           cnt_d = cnt_q + 1'b1;
                if (in_last)               state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef REFLET_FLOAT_MINMAX_INDEX_EN
    // The beat index equals the pre-increment count, which also stalls at saturation.
    logic [count_size-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;

    always_comb begin
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        if (state_q == IDLE && start) begin
            min_idx_d = '0;
            max_idx_d = '0;
        end else if (accept) begin
            if (cnt_q == '0 || lt_min) min_idx_d = cnt_q;
            if (cnt_q == '0 || gt_max) max_idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign min_idx = min_idx_q;
    assign max_idx = max_idx_q;
`endif

endmodule
